// File: rtl/simple_bus_pkg.sv
// Shared types and pattern function for the simple_bus memory self-test master.
package simple_bus_pkg;

    localparam int unsigned AW_DEF = 4;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Test pattern: seed plus zero-extended address, wrapping modulo 2**DW.
    function automatic logic [DW_DEF-1:0] exp_word(input logic [DW_DEF-1:0] seed,
                                                   input logic [AW_DEF-1:0] addr);
        return seed + DW_DEF'(addr);
    endfunction

endpackage

// File: rtl/mem_test_checker.sv
// Read-back checker: tags each issued read, compares the returned word one cycle
// later and accumulates a saturating error count plus the first failing address.
module mem_test_checker
    import simple_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          rd_issue,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] seed,
    input  logic [DW-1:0] rdata,
    output logic [CW-1:0] err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [CW-1:0] err_count_nxt_c
);

    logic          tag_valid_q, tag_valid_d;
    logic [AW-1:0] tag_addr_q, tag_addr_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic [AW-1:0] first_err_addr_q, first_err_addr_d;
    logic [DW-1:0] exp_c;
    logic          mismatch_c;

    always_comb begin
        tag_valid_d      = rd_issue;
        tag_addr_d       = rd_addr;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        exp_c            = DW'(exp_word(DW_DEF'(seed), AW_DEF'(tag_addr_q)));
        mismatch_c       = tag_valid_q && (rdata != exp_c);
        if (clear) begin
            err_count_d      = '0;
            first_err_addr_d = '0;
        end else if (mismatch_c) begin
            if (err_count_q < CW'(DEPTH)) begin
                err_count_d = err_count_q + CW'(1);
            end
            // A zero count means this is the first mismatch of the run.
            if (err_count_q == '0) begin
                first_err_addr_d = tag_addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q      <= 1'b0;
            tag_addr_q       <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            tag_valid_q      <= tag_valid_d;
            tag_addr_q       <= tag_addr_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign err_count       = err_count_q;
    assign first_err_addr  = first_err_addr_q;
    assign err_count_nxt_c = err_count_d;

endmodule

// File: rtl/simple_bus_mem_tester.sv
// Self-test bus master: writes seed+addr to every word, reads it all back and
// reports pass/fail, error count and first failing address.
module simple_bus_mem_tester
    import simple_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [AW-1:0] bus_addr,
    output logic          bus_wr,
    output logic          bus_rd,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] seed_q, seed_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic          bus_wr_q, bus_wr_d;
    logic          bus_rd_q, bus_rd_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          clear_c;
    logic [CW-1:0] err_count_nxt_c;

    // bus_addr_q doubles as the walk index; outputs are set up for the next state.
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        bus_addr_d  = '0;
        bus_wr_d    = 1'b0;
        bus_rd_d    = 1'b0;
        bus_wdata_d = '0;
        clear_c     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    seed_d      = seed;
                    pass_d      = 1'b0;
                    clear_c     = 1'b1;
                    bus_wr_d    = 1'b1;
                    bus_wdata_d = DW'(exp_word(DW_DEF'(seed), AW_DEF'(0)));
                end
            end
            ST_WRITE: begin
                if (bus_addr_q == LAST_ADDR) begin
                    state_d  = ST_READ;
                    bus_rd_d = 1'b1;
                end else begin
                    bus_addr_d  = bus_addr_q + AW'(1);
                    bus_wr_d    = 1'b1;
                    bus_wdata_d = DW'(exp_word(DW_DEF'(seed_q), AW_DEF'(bus_addr_d)));
                end
            end
            ST_READ: begin
                if (bus_addr_q == LAST_ADDR) begin
                    state_d = ST_CHECK;
                end else begin
                    bus_addr_d = bus_addr_q + AW'(1);
                    bus_rd_d   = 1'b1;
                end
            end
            ST_CHECK: begin
                // Include the final read's comparison, which lands on this same edge.
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = (err_count_nxt_c == '0);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            bus_addr_q  <= '0;
            bus_wr_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            bus_addr_q  <= bus_addr_d;
            bus_wr_q    <= bus_wr_d;
            bus_rd_q    <= bus_rd_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    mem_test_checker #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_checker (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear_c),
        .rd_issue        (bus_rd_q),
        .rd_addr         (bus_addr_q),
        .seed            (seed_q),
        .rdata           (bus_rdata),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr),
        .err_count_nxt_c (err_count_nxt_c)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wr    = bus_wr_q;
    assign bus_rd    = bus_rd_q;
    assign bus_wdata = bus_wdata_q;

endmodule
